otp_cifra_serial: RTL and testbench
===================================

// Module: otp_cifra_serial
//
// PURPOSE
// Upstream neighbour of the OTP decipher stage.
// - Accepts plaintext one byte per handshake and XORs each byte with a repeating 32-bit one-time pad.
// - Packs 8 ciphered bytes into one 64-bit word and presents it on a valid/ready output.
// - The packing matches the decipher bit mapping: cipher[i] = plain[i] ^ otp[i mod 32].
//
// PARAMETERS
// BITS      64  output cipher word width; must be a multiple of KEY_BITS and of 8
// KEY_BITS  32  one-time pad width; must be a multiple of 8
//
// PORTS
// clk        in   1         single clock, rising edge
// rst        in   1         synchronous reset, active-high
// key_load   in   1         load key_in into pad register (see rules)
// key_in     in   KEY_BITS  one-time pad value
// in_valid   in   1         in_byte valid
// in_ready   out  1         block accepts a byte this cycle
// in_byte    in   8         plaintext byte, first byte of word sent first
// out_valid  out  1         out_word holds a complete cipher word
// out_ready  in   1         downstream consumes out_word
// out_word   out  BITS      cipher word, byte 0 in [BITS-1:BITS-8]
// byte_cnt   out  4         bytes collected in current word (0..BITS/8)
//
// BEHAVIOUR
// - Reset (rst=1 at a clk edge) sets:
//     state=COLLECT, byte_cnt=0, otp=0, out_word=0, out_valid=0.
//   in_ready is 1 from the first cycle after reset.
// - Reset mid-word or while in HOLD discards the partial or pending word. The key is cleared.
// - FSM has 2 states:
//     COLLECT: in_ready=1, out_valid=0.
//     HOLD:    in_ready=0, out_valid=1.
// - In COLLECT, a byte transfer occurs when in_valid && in_ready. For byte k = byte_cnt:
//     out_word[BITS-1-8k -: 8] <= in_byte ^ otp[KEY_BITS-1-8(k mod (KEY_BITS/8)) -: 8]
//     byte_cnt <= k+1
// - The transfer of byte k = BITS/8-1 moves the FSM to HOLD.
//   out_valid rises the next cycle, giving 1-cycle latency from the last byte to out_valid.
//   byte_cnt reads BITS/8 while in HOLD.
// - In HOLD, out_word and out_valid stay stable until out_ready=1.
//   On out_valid && out_ready, the next state is COLLECT and byte_cnt=0.
// - An in_byte offered during HOLD is not accepted, because in_ready=0.
// - No bubble is required beyond the HOLD->COLLECT edge: a new byte can be accepted in the cycle after the pop.
// - key_load is honoured only when state=COLLECT and byte_cnt=0.
//   Otherwise it is ignored, so a word is never ciphered with mixed keys.
// - If key_load and a byte transfer occur in the same cycle at byte_cnt=0:
//     the byte uses the old key;
//     the new key applies from byte 1.
//   Drivers must load the key at least 1 cycle before the first byte.
// - The XOR is combinational on registered key bits. out_word is registered.
//   Unwritten bytes of a partial word hold their previous values.
//   out_word is defined only when out_valid=1.
// - in_valid held high with in_ready low is legal. The byte is taken when in_ready returns.
//
// TESTING
// 1. Reset: assert rst for 2 cycles mid-word (byte_cnt=3) -> byte_cnt=0, out_valid=0,
//    in_ready=1 next cycle, out_word=0.
// 2. Known vector: key 0x66697665, bytes "estrelas"
//    (65 73 74 72 65 6C 61 73) back-to-back -> out_valid 1 cycle after the 8th byte,
//    out_word=64'h031A0217_03051716 (matches decipher input).
// 3. Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 ->
//    in_ready=0, out_word unchanged. Raise out_ready -> next cycle in_ready=1 and byte 0 of the next word is accepted.
// 4. Gapped input: toggle in_valid 1/0 per cycle -> same out_word as test 2; byte_cnt increments only on transfers.
// 5. Key rules: key_load=1 with key 0xFFFFFFFF at byte_cnt=4 -> ignored, word equals test 2.
//    key_load with key 0 at byte_cnt=0 and no byte -> next word out_word=plaintext bytes unchanged.
// 6. Back-to-back words: 3 words streamed with out_ready tied 1 -> 3 out_valid pulses, each 1 cycle, each word correct.

Source files
------------

// File: rtl/otp_cifra_serial.sv
// otp_cifra_serial: byte-serial one-time-pad cipher and 64-bit word packer.
// Each accepted plaintext byte is XORed with the matching byte of a repeating
// KEY_BITS pad. BITS/8 ciphered bytes are packed MSB-first into out_word,
// which is then held on a valid/ready output until it is consumed.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous reset, active-high
//   key_load   in   1         load key_in (only at word start, state COLLECT)
//   key_in     in   KEY_BITS  one-time pad value
//   in_valid   in   1         in_byte valid
//   in_ready   out  1         byte accepted this cycle when in_valid is high
//   in_byte    in   8         plaintext byte, first byte of a word sent first
//   out_valid  out  1         out_word holds a complete cipher word
//   out_ready  in   1         downstream consumes out_word
//   out_word   out  BITS      cipher word, byte 0 in [BITS-1:BITS-8]
//   byte_cnt   out  4         bytes collected in the current word
module otp_cifra_serial #(
    parameter int unsigned BITS     = 64,
    parameter int unsigned KEY_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_byte,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     out_word,
    output logic [3:0]          byte_cnt
);

    localparam int unsigned NBYTES = BITS / 8;
    localparam int unsigned KBYTES = KEY_BITS / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [CNT_W-1:0]    w_byte_cnt_nxt;
    logic [KEY_BITS-1:0] r_otp;
    logic [KEY_BITS-1:0] w_otp_nxt;
    logic [BITS-1:0]     r_word;
    logic [BITS-1:0]     w_word_nxt;
    logic                r_in_ready;
    logic                w_in_ready_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic                w_xfer;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_byte_cnt  <= '0;
            r_otp       <= '0;
            r_word      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_otp       <= w_otp_nxt;
            r_word      <= w_word_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state, byte insertion and handshake flags
    always_comb begin
        w_state_nxt     = r_state;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_otp_nxt       = r_otp;
        w_word_nxt      = r_word;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;
        w_xfer          = 1'b0;

        case (r_state)
            S_COLLECT: begin
                w_xfer = in_valid;
                // Key changes only at a word boundary; a same-cycle byte 0 still sees the old key.
                if (key_load && (r_byte_cnt == '0)) begin
                    w_otp_nxt = key_in;
                end
                if (w_xfer) begin
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (r_byte_cnt == CNT_W'(i)) begin
                            w_word_nxt[BITS-1-8*i -: 8] =
                                in_byte ^ r_otp[KEY_BITS-1-8*(i%KBYTES) -: 8];
                        end
                    end
                    w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                    if (r_byte_cnt == CNT_W'(NBYTES-1)) begin
                        w_state_nxt     = S_HOLD;
                        w_in_ready_nxt  = 1'b0;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt     = S_COLLECT;
                    w_byte_cnt_nxt  = '0;
                    w_in_ready_nxt  = 1'b1;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = r_word;
    assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_otp_cifra_serial.sv
// Self-checking bench for otp_cifra_serial with a word-level cipher model.
module tb_otp_cifra_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [31:0] key_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_word;
    logic [3:0]  byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit to_err   = 1'b0;

    localparam logic [31:0] KEY_FIVE = 32'h66697665;
    localparam logic [63:0] EST_CIPH = 64'h031A0217_03051716;
    logic [7:0] est[8] = '{8'h65, 8'h73, 8'h74, 8'h72, 8'h65, 8'h6C, 8'h61, 8'h73};

    otp_cifra_serial #(.BITS(64), .KEY_BITS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_in   (key_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_byte  (in_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    // Reference: concatenate bytes, byte i XORed with pad byte (i mod 4), most significant first.
    function automatic logic [63:0] model(input logic [31:0] key, input logic [7:0] p[8]);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w = {w[55:0], p[i] ^ 8'(key >> (8 * (3 - (i % 4))))};
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte until accepted (bounded).
    task automatic push_byte(input logic [7:0] b);
        bit taken;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int c = 0; c < 50 && !done; c++) begin
            taken = in_ready;
            tick();
            if (taken) done = 1'b1;
        end
        if (!done) to_err = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] p[8]);
        for (int i = 0; i < 8; i++) push_byte(p[i]);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
    endtask

    task automatic rand_bytes(output logic [7:0] p[8]);
        for (int i = 0; i < 8; i++) p[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        logic [7:0] p[8];
        logic [63:0] plain;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_checks++; if (byte_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", byte_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ir got %b exp 1", in_ready); end
        n_checks++; if (out_word !== 64'd0) begin n_fail++; $display("FAIL reset_word got %h exp 0", out_word); end
        // Reset mid-word discards partial word and clears the key
        load_key($urandom);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
        n_checks++; if (byte_cnt !== 4'd3) begin n_fail++; $display("FAIL mid_cnt got %0d exp 3", byte_cnt); end
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_checks++; if (byte_cnt !== 4'd0) begin n_fail++; $display("FAIL rst2_cnt got %0d exp 0", byte_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst2_ov got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst2_ir got %b exp 1", in_ready); end
        n_checks++; if (out_word !== 64'd0) begin n_fail++; $display("FAIL rst2_word got %h exp 0", out_word); end
        rand_bytes(p);
        push_word(p);
        plain = model(32'd0, p);
        n_checks++; if (out_word !== plain) begin n_fail++; $display("FAIL key_cleared got %h exp %h", out_word, plain); end
        pop();
        n_checks++; if (to_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", to_err); end
    endtask

    task automatic test_known();
        load_key(KEY_FIVE);
        for (int i = 0; i < 8; i++) begin
            push_byte(est[i]);
            n_checks++; if (byte_cnt !== 4'(i + 1)) begin n_fail++; $display("FAIL known_cnt%0d got %0d exp %0d", i, byte_cnt, i + 1); end
            n_checks++; if (out_valid !== (i == 7)) begin n_fail++; $display("FAIL known_ov%0d got %b exp %b", i, out_valid, i == 7); end
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL known_ir got %b exp 0", in_ready); end
        n_checks++; if (out_word !== EST_CIPH) begin n_fail++; $display("FAIL known_word got %h exp %h", out_word, EST_CIPH); end
        n_checks++; if (out_word !== model(KEY_FIVE, est)) begin n_fail++; $display("FAIL known_model got %h exp %h", out_word, model(KEY_FIVE, est)); end
        pop();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL known_pop_ov got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL known_pop_ir got %b exp 1", in_ready); end
        n_checks++; if (byte_cnt !== 4'd0) begin n_fail++; $display("FAIL known_pop_cnt got %0d exp 0", byte_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  p[8];
        logic [7:0]  q[8];
        logic [63:0] exp_w;
        rand_bytes(p);
        rand_bytes(q);
        push_word(p);
        exp_w = model(KEY_FIVE, p);
        in_valid  = 1'b1;
        in_byte   = q[0];
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ir%0d got %b exp 0", c, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_ov%0d got %b exp 1", c, out_valid); end
            n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL bp_word%0d got %h exp %h", c, out_word, exp_w); end
            n_checks++; if (byte_cnt !== 4'd8) begin n_fail++; $display("FAIL bp_cnt%0d got %0d exp 8", c, byte_cnt); end
        end
        pop();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_ir got %b exp 1", in_ready); end
        n_checks++; if (byte_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_pop_cnt got %0d exp 0", byte_cnt); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (byte_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_next_cnt got %0d exp 1", byte_cnt); end
        for (int i = 1; i < 8; i++) push_byte(q[i]);
        exp_w = model(KEY_FIVE, q);
        n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL bp_next_word got %h exp %h", out_word, exp_w); end
        pop();
        n_checks++; if (to_err !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b exp 0", to_err); end
    endtask

    task automatic test_gapped();
        logic [7:0]  p[8];
        logic [31:0] k;
        logic [63:0] exp_w;
        int          idx;
        bit          taken;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_byte = est[i];
            tick();
            n_checks++; if (byte_cnt !== 4'(i + 1)) begin n_fail++; $display("FAIL gap_on%0d got %0d exp %0d", i, byte_cnt, i + 1); end
            in_valid = 1'b0; in_byte = 8'($urandom_range(0, 255));
            tick();
            n_checks++; if (byte_cnt !== 4'(i + 1)) begin n_fail++; $display("FAIL gap_off%0d got %0d exp %0d", i, byte_cnt, i + 1); end
        end
        n_checks++; if (out_word !== EST_CIPH) begin n_fail++; $display("FAIL gap_word got %h exp %h", out_word, EST_CIPH); end
        pop();
        // Random key, random gaps
        k = $urandom;
        load_key(k);
        rand_bytes(p);
        idx = 0;
        for (int c = 0; c < 100 && idx < 8; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_byte  = p[idx];
            taken    = in_valid && in_ready;
            tick();
            if (taken) idx++;
        end
        in_valid = 1'b0;
        exp_w = model(k, p);
        n_checks++; if (idx !== 8) begin n_fail++; $display("FAIL rgap_count got %0d exp 8", idx); end
        n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL rgap_word got %h exp %h", out_word, exp_w); end
        pop();
    endtask

    task automatic test_key_rules();
        logic [7:0]  p[8];
        logic [31:0] ka;
        logic [31:0] kb;
        logic [63:0] exp_w;
        load_key(KEY_FIVE);
        for (int i = 0; i < 4; i++) push_byte(est[i]);
        load_key(32'hFFFF_FFFF);
        n_checks++; if (byte_cnt !== 4'd4) begin n_fail++; $display("FAIL key_mid_cnt got %0d exp 4", byte_cnt); end
        for (int i = 4; i < 8; i++) push_byte(est[i]);
        n_checks++; if (out_word !== EST_CIPH) begin n_fail++; $display("FAIL key_mid_word got %h exp %h", out_word, EST_CIPH); end
        // key_load during HOLD ignored
        load_key(32'h1234_5678);
        pop();
        rand_bytes(p);
        push_word(p);
        exp_w = model(KEY_FIVE, p);
        n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL key_hold_word got %h exp %h", out_word, exp_w); end
        pop();
        // Zero key gives plaintext
        load_key(32'd0);
        rand_bytes(p);
        push_word(p);
        exp_w = model(32'd0, p);
        n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL key_zero_word got %h exp %h", out_word, exp_w); end
        pop();
        // key_load with byte 0 in same cycle: byte 0 old key, rest new key
        ka = $urandom;
        kb = $urandom;
        load_key(ka);
        rand_bytes(p);
        key_load = 1'b1; key_in = kb; in_valid = 1'b1; in_byte = p[0];
        tick();
        key_load = 1'b0; in_valid = 1'b0;
        n_checks++; if (byte_cnt !== 4'd1) begin n_fail++; $display("FAIL key_same_cnt got %0d exp 1", byte_cnt); end
        for (int i = 1; i < 8; i++) push_byte(p[i]);
        exp_w = model(kb, p);
        exp_w[63:56] = p[0] ^ ka[31:24];
        n_checks++; if (out_word !== exp_w) begin n_fail++; $display("FAIL key_same_word got %h exp %h", out_word, exp_w); end
        pop();
        n_checks++; if (to_err !== 1'b0) begin n_fail++; $display("FAIL key_timeout got %b exp 0", to_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  all_b[24];
        logic [7:0]  p[8];
        logic [63:0] exp_q[3];
        logic [31:0] k;
        int          idx;
        int          pulses;
        bit          taken;
        bit          prev_ov;
        k = $urandom;
        load_key(k);
        for (int w = 0; w < 3; w++) begin
            rand_bytes(p);
            for (int i = 0; i < 8; i++) all_b[w*8+i] = p[i];
            exp_q[w] = model(k, p);
        end
        idx = 0; pulses = 0; prev_ov = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && pulses < 3; c++) begin
            in_valid = (idx < 24);
            in_byte  = (idx < 24) ? all_b[idx] : 8'h00;
            taken    = in_valid && in_ready;
            tick();
            if (taken) idx++;
            if (out_valid) begin
                n_checks++; if (prev_ov !== 1'b0) begin n_fail++; $display("FAIL b2b_width%0d got %b exp 0", pulses, prev_ov); end
                n_checks++; if (out_word !== exp_q[pulses]) begin n_fail++; $display("FAIL b2b_word%0d got %h exp %h", pulses, out_word, exp_q[pulses]); end
                pulses++;
            end
            prev_ov = out_valid;
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_ov got %b exp 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0;
        in_byte = '0; out_ready = 1'b0;
        test_reset();
        test_known();
        test_backpressure();
        test_gapped();
        test_key_rules();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
